trng_collector: RTL and testbench

Post-processing stage directly downstream of the ring-oscillator TRNG core. It drives the oscillator enable and synchronizes the raw 1-bit TRNG output. It runs a repetition-count health test on the raw stream, removes bias with a von Neumann extractor, and packs the result into words. Words are buffered in a small FIFO and offered to the bus-side consumer over a valid/ready handshake.

---
 rtl/trng_pkg.sv | 17 +
 rtl/trng_fifo.sv | 55 +++++
 rtl/trng_collector.sv | 148 ++++++++++++++
 tb/tb_trng_collector.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG post-processing collector.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2,
        FAIL    = 2'd3
    } state_t;

    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_WARMUP_CYCLES = 16;
    localparam int DEF_REP_LIMIT     = 32;
    localparam int SYNC_STAGES       = 2;

endpackage

// File: rtl/trng_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on rd_data.
module trng_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_FULL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/trng_collector.sv
// TRNG post-processing: synchronizer, warm-up FSM, repetition health test,
// von Neumann extractor and word packer feeding an output FIFO.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  trng_in,
    output logic                  trng_en,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  health_fail
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam int CNT_W  = $clog2(WORD_WIDTH + 1);

    state_t                  state_reg, state_next;
    logic [SYNC_STAGES-1:0]  sync_reg;
    logic                    raw_s;
    logic                    prev_raw_reg;
    logic [WARM_W-1:0]       warm_cnt_reg;
    logic [REP_W-1:0]        rep_cnt_reg;
    logic [REP_W-1:0]        rep_next;
    logic                    phase_reg;
    logic                    first_bit_reg;
    logic [WORD_WIDTH-1:0]   word_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic                    health_fail_reg;
    logic                    trng_en_reg;

    logic in_collect, enter_collect, leave_collect;
    logic trip, emit, word_full, push, push_ok, pop;
    logic fifo_full, fifo_empty;

    assign raw_s      = sync_reg[SYNC_STAGES-1];
    assign in_collect = (state_reg == COLLECT);
    assign rep_next   = (raw_s == prev_raw_reg) ? rep_cnt_reg + REP_W'(1) : REP_W'(1);
    // clear and a same-cycle disable both win over a health trip.
    assign trip       = in_collect && enable && !clear && (rep_next == REP_W'(REP_LIMIT));
    assign emit       = in_collect && phase_reg && (first_bit_reg != raw_s);
    assign word_full  = (bit_cnt_reg == CNT_W'(WORD_WIDTH));
    assign push       = word_full && !clear && !trip;
    assign pop        = valid && ready;
    assign push_ok    = push && (!fifo_full || pop);

    assign enter_collect = (state_reg != COLLECT) && (state_next == COLLECT);
    assign leave_collect = in_collect && (state_next != COLLECT);

    assign valid       = !fifo_empty;
    assign trng_en     = trng_en_reg;
    assign health_fail = health_fail_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable && !health_fail_reg) state_next = WARMUP;
            WARMUP: begin
                if (!enable) state_next = IDLE;
                else if (warm_cnt_reg == WARM_W'(WARMUP_CYCLES - 1)) state_next = COLLECT;
            end
            COLLECT: begin
                if (!enable) state_next = IDLE;
                else if (trip) state_next = FAIL;
            end
            FAIL:    if (clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            sync_reg        <= '0;
            prev_raw_reg    <= 1'b0;
            trng_en_reg     <= 1'b0;
            warm_cnt_reg    <= '0;
            rep_cnt_reg     <= '0;
            health_fail_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], trng_in};
            prev_raw_reg <= raw_s;
            trng_en_reg  <= (state_next == WARMUP) || (state_next == COLLECT);

            if (state_reg == IDLE && state_next == WARMUP) warm_cnt_reg <= '0;
            else if (state_reg == WARMUP)                  warm_cnt_reg <= warm_cnt_reg + 1'b1;

            if (enter_collect)   rep_cnt_reg <= REP_W'(1);
            else if (in_collect) rep_cnt_reg <= rep_next;

            if (clear)     health_fail_reg <= 1'b0;
            else if (trip) health_fail_reg <= 1'b1;
        end
    end

    // Extractor pair phase and packer; a completed word waits here while the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg     <= 1'b0;
            first_bit_reg <= 1'b0;
            word_reg      <= '0;
            bit_cnt_reg   <= '0;
        end else begin
            if (clear || enter_collect || leave_collect) begin
                phase_reg <= 1'b0;
            end else if (in_collect) begin
                phase_reg <= ~phase_reg;
                if (!phase_reg) first_bit_reg <= raw_s;
            end

            if (clear || trip || leave_collect) begin
                word_reg    <= '0;
                bit_cnt_reg <= '0;
            end else if (push_ok) begin
                bit_cnt_reg <= '0;
            end else if (emit && !word_full) begin
                word_reg    <= {word_reg[WORD_WIDTH-2:0], first_bit_reg};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    trng_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (clear || trip),
        .push    (push),
        .pop     (pop),
        .wr_data (word_reg),
        .rd_data (data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: edge-indexed vector tables plus short hand-written sequences.
module tb_trng_collector;

    localparam int W = 32;
    localparam int M_RAND  = 0;
    localparam int M_WORDS = 1;
    localparam int M_RPT   = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic         trng_in = 1'b0;
    logic         ready = 1'b0;
    logic         trng_en;
    logic         valid;
    logic         health_fail;
    logic [W-1:0] data;

    trng_collector #(
        .WORD_WIDTH    (W),
        .FIFO_DEPTH    (4),
        .WARMUP_CYCLES (16),
        .REP_LIMIT     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .trng_in     (trng_in),
        .trng_en     (trng_en),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    int           mode = M_RAND;
    int           ones_from = 32'h3fffffff;
    logic [W-1:0] wv [8];
    int           edge_idx = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    typedef struct {
        int           edge_no;
        logic         rdy;
        logic         en;
        logic         clr;
        logic         ev;
        logic [W-1:0] ed;
        logic         et;
        logic         eh;
    } vec_t;

    vec_t vecs[$];

    // Raw bit driven after edge k; processing pair j sees bits k=15+2j and k=16+2j.
    function automatic logic gen_bit(int k);
        logic [W-1:0] w;
        int           j;
        int           i;
        logic         b;
        if (mode == M_RAND) return 1'($urandom_range(0, 1));
        if (k >= ones_from) return 1'b1;
        if (k < 15) return k[0];
        if (mode == M_RPT) begin
            case ((k - 15) % 6)
                0, 2, 3: return 1'b1;
                default: return 1'b0;
            endcase
        end
        j = (k - 15) / 2;
        w = wv[(j / 32) % 8];
        i = j % 32;
        b = w[31 - i];
        return (((k - 15) % 2) == 0) ? b : ~b;
    endfunction

    function automatic vec_t mk(int e, logic r, logic en, logic c, logic ev,
                                logic [W-1:0] ed, logic et, logic eh);
        vec_t v;
        v.edge_no = e; v.rdy = r; v.en = en; v.clr = c;
        v.ev = ev; v.ed = ed; v.et = et; v.eh = eh;
        return v;
    endfunction

    task automatic check1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, edge_idx, act, exp);
        end
    endtask

    task automatic checkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_idx++;
        trng_in = gen_bit(edge_idx);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic start();
        enable = 1'b1;
        edge_idx = 0;
        trng_in = gen_bit(0);
    endtask

    task automatic run_table();
        foreach (vecs[n]) begin
            int guard;
            guard = 0;
            while (edge_idx < vecs[n].edge_no && guard < 4000) begin
                step();
                guard++;
            end
            if (edge_idx != vecs[n].edge_no) begin
                n_fail++;
                $display("FAIL table_sync: at edge %0d wanted edge %0d", edge_idx, vecs[n].edge_no);
            end
            check1("valid", valid, vecs[n].ev);
            check1("trng_en", trng_en, vecs[n].et);
            check1("health_fail", health_fail, vecs[n].eh);
            if (vecs[n].ev) checkw("data", data, vecs[n].ed);
            ready  = vecs[n].rdy;
            enable = vecs[n].en;
            if (vecs[n].clr) clear = 1'b1;
        end
        vecs.delete();
    endtask

    task automatic count_words(int last_edge, logic [W-1:0] exp_word,
                               output int nwords, output int first_e, output int last_e);
        nwords = 0; first_e = -1; last_e = -1;
        while (edge_idx < last_edge) begin
            step();
            if (edge_idx == 1) check1("trng_en_rise", trng_en, 1'b1);
            if (valid) begin
                nwords++;
                if (first_e < 0) first_e = edge_idx;
                last_e = edge_idx;
                checkw("word", data, exp_word);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_idx);
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, fe, le;

        // Reset with random raw input and enable low: nothing may happen.
        mode = M_RAND;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_trng_en", trng_en, 1'b0);
        check1("rst_valid", valid, 1'b0);
        check1("rst_health", health_fail, 1'b0);
        checkw("rst_data", data, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checkw("idle_outputs", {29'd0, trng_en, valid, health_fail}, '0);
        end

        // Alternating 0,1 stream: zero words, one per 64 COLLECT cycles.
        do_reset();
        mode = M_WORDS;
        foreach (wv[i]) wv[i] = '0;
        ones_from = 32'h3fffffff;
        ready = 1'b1;
        start();
        check1("trng_en_before_rise", trng_en, 1'b0);
        count_words(274, '0, nw, fe, le);
        checkw("alt_word_count", 32'(nw), 32'd4);
        checkw("alt_first_edge", 32'(fe), 32'd82);
        checkw("alt_last_edge", 32'(le), 32'd274);

        // 10,11,00 pattern: only the 10 pairs emit, one bit per 6 cycles.
        do_reset();
        mode = M_RPT;
        ready = 1'b1;
        start();
        count_words(398, 32'hFFFF_FFFF, nw, fe, le);
        checkw("rpt_word_count", 32'(nw), 32'd2);
        checkw("rpt_first_edge", 32'(fe), 32'd206);
        checkw("rpt_last_edge", 32'(le), 32'd398);

        // Backpressure: four words fill the FIFO, the fifth is held until ready returns.
        do_reset();
        mode = M_WORDS;
        wv[0] = 32'hC0FF_EE01; wv[1] = 32'h1234_5678; wv[2] = 32'hA5A5_F00F;
        wv[3] = 32'h0BAD_CAFE; wv[4] = 32'hDEAD_BEEF; wv[5] = 32'h0000_FFFF;
        wv[6] = 32'h8000_0001; wv[7] = 32'h7777_1111;
        ready = 1'b0;
        start();
        vecs.push_back(mk(1,   0, 1, 0, 0, '0,    1, 0));
        vecs.push_back(mk(81,  0, 1, 0, 0, '0,    1, 0));
        vecs.push_back(mk(82,  0, 1, 0, 1, wv[0], 1, 0));
        vecs.push_back(mk(275, 0, 1, 0, 1, wv[0], 1, 0));
        vecs.push_back(mk(340, 1, 1, 0, 1, wv[0], 1, 0));
        vecs.push_back(mk(341, 1, 1, 0, 1, wv[1], 1, 0));
        vecs.push_back(mk(342, 1, 1, 0, 1, wv[2], 1, 0));
        vecs.push_back(mk(343, 1, 1, 0, 1, wv[3], 1, 0));
        vecs.push_back(mk(344, 1, 1, 0, 1, wv[4], 1, 0));
        vecs.push_back(mk(345, 1, 1, 0, 0, '0,    1, 0));
        run_table();

        // Stuck-at-1 from k=80: run counted from edge 83, trip at edge 114; clear at 121.
        do_reset();
        foreach (wv[i]) wv[i] = '0;
        ones_from = 80;
        ready = 1'b0;
        start();
        vecs.push_back(mk(82,  0, 1, 0, 1, '0, 1, 0));
        vecs.push_back(mk(113, 0, 1, 0, 1, '0, 1, 0));
        vecs.push_back(mk(114, 0, 1, 0, 0, '0, 0, 1));
        vecs.push_back(mk(120, 0, 1, 1, 0, '0, 0, 1));
        vecs.push_back(mk(121, 0, 1, 0, 0, '0, 0, 0));
        vecs.push_back(mk(122, 0, 1, 0, 0, '0, 1, 0));
        run_table();

        // Disable at bit_cnt=17, then re-enable: first word must be wv[0] from scratch.
        do_reset();
        ones_from = 32'h3fffffff;
        wv[0] = 32'h5A3C_9617; wv[1] = 32'hF0E1_D2C3;
        ready = 1'b1;
        start();
        vecs.push_back(mk(51, 1, 0, 0, 0, '0, 1, 0));
        vecs.push_back(mk(52, 1, 0, 0, 0, '0, 0, 0));
        vecs.push_back(mk(60, 1, 0, 0, 0, '0, 0, 0));
        run_table();
        start();
        while (edge_idx < 82) begin
            step();
            if (edge_idx == 1)  check1("reen_trng_en", trng_en, 1'b1);
            if (edge_idx == 81) check1("reen_valid_early", valid, 1'b0);
        end
        check1("reen_valid", valid, 1'b1);
        checkw("reen_word", data, wv[0]);

        // Asynchronous reset with words queued: outputs drop without a clock edge.
        do_reset();
        ready = 1'b0;
        start();
        while (edge_idx < 150) step();
        check1("pre_areset_valid", valid, 1'b1);
        checkw("pre_areset_data", data, wv[0]);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check1("areset_valid", valid, 1'b0);
        check1("areset_trng_en", trng_en, 1'b0);
        check1("areset_health", health_fail, 1'b0);
        checkw("areset_data", data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        check1("post_areset_valid", valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
